pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter REG_ID_W, default 5, register-ID width.
REQ-002 Parameter DATA_W, default 32, operand data width.
REQ-003 Parameter MEM_WAIT, default 0, data-memory wait cycles per load/store; range 0..15.
REQ-004 Parameter FWD_EN, default 1, forwarding mode; 1 = forward, 0 = stall-only.
REQ-005 Ports: clk  in  1  clock; reset_n  in  1  reset, synchronous, active-low.
REQ-006 Ports: id_rs1, id_rs2  in  REG_ID_W  ID-stage sources; id_rs1_used, id_rs2_used  in  1  source valid.
REQ-007 Ports: ex_rs1, ex_rs2  in  REG_ID_W  EX-stage sources; ex_rs1_data, ex_rs2_data  in  DATA_W  register-file values.
REQ-008 Ports: ex_rd  in  REG_ID_W; ex_reg_write, ex_mem_read, ex_branch_taken  in  1; all describe the EX-stage instruction.
REQ-009 Ports: mem_rd  in  REG_ID_W; mem_reg_write, mem_mem_access  in  1; mem_data  in  DATA_W; all describe the MEM-stage instruction.
REQ-010 Ports: wb_rd  in  REG_ID_W; wb_reg_write  in  1; wb_data  in  DATA_W; all describe the WB-stage instruction.
REQ-011 Ports: pc_en, if_id_en, id_ex_en, ex_mem_en  out  1  register load enables.
REQ-012 Ports: if_id_flush, id_ex_flush, mem_wb_flush  out  1  bubble insertion.
REQ-013 Ports: fwd_a_sel, fwd_b_sel  out  2  (0 reg, 1 MEM, 2 WB); op_a, op_b  out  DATA_W  forwarded operands.
REQ-014 Ports: stall_cycles, flush_count  out  32  performance counters.

Function
REQ-015 match(x,rd,we) = we & (rd != 0) & (x == rd); register 0 never matches.
REQ-016 Default outputs (no hazard): all enables 1, all flushes 0.
REQ-017 FSM states: RUN, WAIT, DONE; 4-bit down-counter cnt.
REQ-018 RUN & mem_mem_access & MEM_WAIT>0: freeze; go to DONE if MEM_WAIT==1, else load cnt=MEM_WAIT-1 and go to WAIT.
REQ-019 WAIT: freeze; cnt decrements; go to DONE when cnt==1; total freeze = exactly MEM_WAIT cycles.
REQ-020 DONE: no freeze and no retrigger for the same access; always go to RUN next cycle.
REQ-021 Freeze: pc_en=if_id_en=id_ex_en=ex_mem_en=0, mem_wb_flush=1, if_id_flush=id_ex_flush=0; branch and load-use ignored.
REQ-022 Branch (not frozen, ex_branch_taken=1): if_id_flush=1, id_ex_flush=1, pc_en=1; overrides load-use.
REQ-023 Load-use (FWD_EN=1, not frozen, no branch): ex_mem_read & (match(id_rs1,ex_rd,ex_reg_write)&id_rs1_used | same for rs2).
REQ-024 Load-use response: pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1; one-cycle stall per occurrence.
REQ-025 FWD_EN=0 RAW stall: any used ID source matching ex_rd or mem_rd gives the REQ-024 response; WB match never stalls.
REQ-026 Forward select (FWD_EN=1): sel=1 if match(ex_rsX,mem_rd,mem_reg_write); else 2 if match(ex_rsX,wb_rd,wb_reg_write); else 0.
REQ-027 MEM match has priority over WB match; FWD_EN=0 forces sel=0.
REQ-028 op_a/op_b = ex_rsX_data, mem_data or wb_data according to sel; combinational, zero latency.
REQ-029 stall_cycles increments every cycle pc_en==0 while reset_n=1; saturates at 0xFFFFFFFF.
REQ-030 flush_count increments once per cycle in which the REQ-022 branch flush is applied; saturates at 0xFFFFFFFF.

Reset
REQ-031 reset_n=0 at a clk edge: state=RUN, cnt=0, stall_cycles=0, flush_count=0.
REQ-032 While reset_n=0: pc_en=0, other enables=1, all flushes=1, fwd sels=0; counters do not count.
REQ-033 Reset during WAIT aborts the freeze; the first cycle after release evaluates as RUN.

Verification
REQ-034 Load x5 in EX, ID uses x5 as rs2 -> one cycle with pc_en=0, id_ex_flush=1; stall_cycles=1.
REQ-035 mem_rd=wb_rd=x3, both writing, ex_rs1=x3, mem_data=0xAA, wb_data=0xBB -> fwd_a_sel=1, op_a=0xAA.
REQ-036 MEM_WAIT=3, store enters MEM -> exactly 3 frozen cycles with mem_wb_flush=1, then a DONE cycle with ex_mem_en=1.
REQ-037 ex_branch_taken concurrent with load-use -> if_id_flush=id_ex_flush=1, pc_en=1; flush_count=1, stall_cycles=0.
REQ-038 FWD_EN=0, ID rs1 equals mem_rd=x7 -> stall; rs1 equals wb_rd only -> no stall; rd=x0 -> never stall or forward.
REQ-039 MEM_WAIT=4, reset_n=0 on the 2nd freeze cycle -> the next cycle is RUN, counters are 0, and the access retriggers a full 4-cycle freeze.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle: ID/EX/MEM/WB descriptors in, pipeline enables,
// flushes, forwarded operands and performance counters out.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_ID_W = 5,
  parameter int DATA_W   = 32
);
  logic [REG_ID_W-1:0] id_rs1, id_rs2;
  logic                id_rs1_used, id_rs2_used;
  logic [REG_ID_W-1:0] ex_rs1, ex_rs2;
  logic [DATA_W-1:0]   ex_rs1_data, ex_rs2_data;
  logic [REG_ID_W-1:0] ex_rd;
  logic                ex_reg_write, ex_mem_read, ex_branch_taken;
  logic [REG_ID_W-1:0] mem_rd;
  logic                mem_reg_write, mem_mem_access;
  logic [DATA_W-1:0]   mem_data;
  logic [REG_ID_W-1:0] wb_rd;
  logic                wb_reg_write;
  logic [DATA_W-1:0]   wb_data;

  logic                pc_en, if_id_en, id_ex_en, ex_mem_en;
  logic                if_id_flush, id_ex_flush, mem_wb_flush;
  logic [1:0]          fwd_a_sel, fwd_b_sel;
  logic [DATA_W-1:0]   op_a, op_b;
  logic [31:0]         stall_cycles, flush_count;

  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           ex_rs1, ex_rs2, ex_rs1_data, ex_rs2_data,
           ex_rd, ex_reg_write, ex_mem_read, ex_branch_taken,
           mem_rd, mem_reg_write, mem_mem_access, mem_data,
           wb_rd, wb_reg_write, wb_data,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en,
           if_id_flush, id_ex_flush, mem_wb_flush,
           fwd_a_sel, fwd_b_sel, op_a, op_b, stall_cycles, flush_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           ex_rs1, ex_rs2, ex_rs1_data, ex_rs2_data,
           ex_rd, ex_reg_write, ex_mem_read, ex_branch_taken,
           mem_rd, mem_reg_write, mem_mem_access, mem_data,
           wb_rd, wb_reg_write, wb_data,
    output pc_en, if_id_en, id_ex_en, ex_mem_en,
           if_id_flush, id_ex_flush, mem_wb_flush,
           fwd_a_sel, fwd_b_sel, op_a, op_b, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// 5-stage pipeline hazard control: memory wait freeze, branch flush,
// load-use / RAW stalls, operand forwarding and stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int REG_ID_W = 5,
  parameter int DATA_W   = 32,
  parameter int MEM_WAIT = 0,
  parameter int FWD_EN   = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {RUN, WAIT, DONE} state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] stall_q, stall_d;
  logic [31:0] flush_q, flush_d;

  logic              freeze, branch, raw_stall;
  logic              pc_en, if_id_en, id_ex_en, ex_mem_en;
  logic              if_id_flush, id_ex_flush, mem_wb_flush;
  logic [1:0]        sel_a, sel_b;
  logic [DATA_W-1:0] op_a, op_b;

  function automatic logic match(input logic [REG_ID_W-1:0] x,
                                 input logic [REG_ID_W-1:0] rd,
                                 input logic                we);
    return we && (rd != '0) && (x == rd);
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: if (hz.mem_mem_access && MEM_WAIT > 0) begin
        if (MEM_WAIT == 1) state_d = DONE;
        else begin
          cnt_d   = WAIT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = DONE;
      end
      DONE:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // The access cycle itself freezes in RUN so the total equals MEM_WAIT.
  assign freeze = reset_n &&
                  ((state_q == RUN && hz.mem_mem_access && MEM_WAIT > 0) ||
                   state_q == WAIT);
  assign branch = reset_n && !freeze && hz.ex_branch_taken;

  always_comb begin
    raw_stall = 1'b0;
    if (FWD_EN != 0) begin
      raw_stall = hz.ex_mem_read &&
        ((match(hz.id_rs1, hz.ex_rd, hz.ex_reg_write) && hz.id_rs1_used) ||
         (match(hz.id_rs2, hz.ex_rd, hz.ex_reg_write) && hz.id_rs2_used));
    end else begin
      raw_stall =
        (hz.id_rs1_used && (match(hz.id_rs1, hz.ex_rd, hz.ex_reg_write) ||
                            match(hz.id_rs1, hz.mem_rd, hz.mem_reg_write))) ||
        (hz.id_rs2_used && (match(hz.id_rs2, hz.ex_rd, hz.ex_reg_write) ||
                            match(hz.id_rs2, hz.mem_rd, hz.mem_reg_write)));
    end
  end

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    if (!reset_n) begin
      pc_en        = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (freeze) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (branch) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (raw_stall) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  // MEM result is younger than WB, so it wins when both target the source.
  always_comb begin
    sel_a = 2'd0;
    sel_b = 2'd0;
    if (reset_n && FWD_EN != 0) begin
      if (match(hz.ex_rs1, hz.mem_rd, hz.mem_reg_write))    sel_a = 2'd1;
      else if (match(hz.ex_rs1, hz.wb_rd, hz.wb_reg_write)) sel_a = 2'd2;
      if (match(hz.ex_rs2, hz.mem_rd, hz.mem_reg_write))    sel_b = 2'd1;
      else if (match(hz.ex_rs2, hz.wb_rd, hz.wb_reg_write)) sel_b = 2'd2;
    end
    case (sel_a)
      2'd1:    op_a = hz.mem_data;
      2'd2:    op_a = hz.wb_data;
      default: op_a = hz.ex_rs1_data;
    endcase
    case (sel_b)
      2'd1:    op_b = hz.mem_data;
      2'd2:    op_b = hz.wb_data;
      default: op_b = hz.ex_rs2_data;
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!pc_en && stall_q != '1) stall_d = stall_q + 32'd1;
    if (branch && flush_q != '1) flush_d = flush_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign hz.pc_en        = pc_en;
  assign hz.if_id_en     = if_id_en;
  assign hz.id_ex_en     = id_ex_en;
  assign hz.ex_mem_en    = ex_mem_en;
  assign hz.if_id_flush  = if_id_flush;
  assign hz.id_ex_flush  = id_ex_flush;
  assign hz.mem_wb_flush = mem_wb_flush;
  assign hz.fwd_a_sel    = sel_a;
  assign hz.fwd_b_sel    = sel_b;
  assign hz.op_a         = op_a;
  assign hz.op_b         = op_b;
  assign hz.stall_cycles = stall_q;
  assign hz.flush_count  = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: three controller configurations (wait=3/fwd, wait=0/no-fwd,
// wait=4/fwd) driven through hand-computed hazard scenarios.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if hz_a ();
  pipeline_hazard_ctrl_if hz_b ();
  pipeline_hazard_ctrl_if hz_c ();

  pipeline_hazard_ctrl #(.MEM_WAIT(3), .FWD_EN(1)) u_a (.clk(clk), .reset_n(reset_n), .hz(hz_a));
  pipeline_hazard_ctrl #(.MEM_WAIT(0), .FWD_EN(0)) u_b (.clk(clk), .reset_n(reset_n), .hz(hz_b));
  pipeline_hazard_ctrl #(.MEM_WAIT(4), .FWD_EN(1)) u_c (.clk(clk), .reset_n(reset_n), .hz(hz_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    hz_a.id_rs1 = '0; hz_a.id_rs2 = '0; hz_a.id_rs1_used = 0; hz_a.id_rs2_used = 0;
    hz_a.ex_rs1 = '0; hz_a.ex_rs2 = '0; hz_a.ex_rs1_data = '0; hz_a.ex_rs2_data = '0;
    hz_a.ex_rd = '0; hz_a.ex_reg_write = 0; hz_a.ex_mem_read = 0; hz_a.ex_branch_taken = 0;
    hz_a.mem_rd = '0; hz_a.mem_reg_write = 0; hz_a.mem_mem_access = 0; hz_a.mem_data = '0;
    hz_a.wb_rd = '0; hz_a.wb_reg_write = 0; hz_a.wb_data = '0;
    hz_b.id_rs1 = '0; hz_b.id_rs2 = '0; hz_b.id_rs1_used = 0; hz_b.id_rs2_used = 0;
    hz_b.ex_rs1 = '0; hz_b.ex_rs2 = '0; hz_b.ex_rs1_data = '0; hz_b.ex_rs2_data = '0;
    hz_b.ex_rd = '0; hz_b.ex_reg_write = 0; hz_b.ex_mem_read = 0; hz_b.ex_branch_taken = 0;
    hz_b.mem_rd = '0; hz_b.mem_reg_write = 0; hz_b.mem_mem_access = 0; hz_b.mem_data = '0;
    hz_b.wb_rd = '0; hz_b.wb_reg_write = 0; hz_b.wb_data = '0;
    hz_c.id_rs1 = '0; hz_c.id_rs2 = '0; hz_c.id_rs1_used = 0; hz_c.id_rs2_used = 0;
    hz_c.ex_rs1 = '0; hz_c.ex_rs2 = '0; hz_c.ex_rs1_data = '0; hz_c.ex_rs2_data = '0;
    hz_c.ex_rd = '0; hz_c.ex_reg_write = 0; hz_c.ex_mem_read = 0; hz_c.ex_branch_taken = 0;
    hz_c.mem_rd = '0; hz_c.mem_reg_write = 0; hz_c.mem_mem_access = 0; hz_c.mem_data = '0;
    hz_c.wb_rd = '0; hz_c.wb_reg_write = 0; hz_c.wb_data = '0;
  endtask

  task automatic do_reset();
    clear_all();
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    clear_all();
    reset_n = 1'b0;
    hz_a.ex_branch_taken = 1'b1;
    hz_a.mem_rd = 5'd3; hz_a.mem_reg_write = 1'b1; hz_a.ex_rs1 = 5'd3;
    repeat (2) tick();
    vecs++; if (hz_a.pc_en !== 1'b0) begin errs++; $display("FAIL rst_pc_en got %0h want 0", hz_a.pc_en); end
    vecs++; if ({hz_a.if_id_en, hz_a.id_ex_en, hz_a.ex_mem_en} !== 3'b111) begin errs++; $display("FAIL rst_enables got %b want 111", {hz_a.if_id_en, hz_a.id_ex_en, hz_a.ex_mem_en}); end
    vecs++; if ({hz_a.if_id_flush, hz_a.id_ex_flush, hz_a.mem_wb_flush} !== 3'b111) begin errs++; $display("FAIL rst_flushes got %b want 111", {hz_a.if_id_flush, hz_a.id_ex_flush, hz_a.mem_wb_flush}); end
    vecs++; if (hz_a.fwd_a_sel !== 2'd0) begin errs++; $display("FAIL rst_fwd_a got %0d want 0", hz_a.fwd_a_sel); end
    vecs++; if (hz_a.stall_cycles !== 32'd0) begin errs++; $display("FAIL rst_stall got %0d want 0", hz_a.stall_cycles); end
    vecs++; if (hz_a.flush_count !== 32'd0) begin errs++; $display("FAIL rst_flush_cnt got %0d want 0", hz_a.flush_count); end
    clear_all();
    reset_n = 1'b1;
    #1;
    vecs++; if ({hz_a.pc_en, hz_a.if_id_en, hz_a.id_ex_en, hz_a.ex_mem_en} !== 4'b1111) begin errs++; $display("FAIL idle_enables got %b want 1111", {hz_a.pc_en, hz_a.if_id_en, hz_a.id_ex_en, hz_a.ex_mem_en}); end
    vecs++; if ({hz_a.if_id_flush, hz_a.id_ex_flush, hz_a.mem_wb_flush} !== 3'b000) begin errs++; $display("FAIL idle_flushes got %b want 000", {hz_a.if_id_flush, hz_a.id_ex_flush, hz_a.mem_wb_flush}); end
  endtask

  task automatic test_load_use();
    do_reset();
    hz_a.ex_mem_read = 1'b1; hz_a.ex_reg_write = 1'b1; hz_a.ex_rd = 5'd5;
    hz_a.id_rs2 = 5'd5; hz_a.id_rs2_used = 1'b1;
    #1;
    vecs++; if ({hz_a.pc_en, hz_a.if_id_en} !== 2'b00) begin errs++; $display("FAIL lu_pc_ifid got %b want 00", {hz_a.pc_en, hz_a.if_id_en}); end
    vecs++; if ({hz_a.id_ex_flush, hz_a.ex_mem_en} !== 2'b11) begin errs++; $display("FAIL lu_flush_exmem got %b want 11", {hz_a.id_ex_flush, hz_a.ex_mem_en}); end
    tick();
    clear_all();
    #1;
    vecs++; if (hz_a.pc_en !== 1'b1) begin errs++; $display("FAIL lu_release got %0h want 1", hz_a.pc_en); end
    vecs++; if (hz_a.stall_cycles !== 32'd1) begin errs++; $display("FAIL lu_stall_cnt got %0d want 1", hz_a.stall_cycles); end
    hz_a.ex_mem_read = 1'b1; hz_a.ex_reg_write = 1'b1; hz_a.ex_rd = 5'd5;
    hz_a.id_rs2 = 5'd5; hz_a.id_rs2_used = 1'b0;
    #1;
    vecs++; if (hz_a.pc_en !== 1'b1) begin errs++; $display("FAIL lu_unused_src got %0h want 1", hz_a.pc_en); end
    hz_a.ex_rd = 5'd0; hz_a.id_rs1 = 5'd0; hz_a.id_rs1_used = 1'b1;
    #1;
    vecs++; if (hz_a.pc_en !== 1'b1) begin errs++; $display("FAIL lu_x0 got %0h want 1", hz_a.pc_en); end
    clear_all();
  endtask

  task automatic test_forward();
    do_reset();
    hz_a.mem_rd = 5'd3; hz_a.mem_reg_write = 1'b1; hz_a.mem_data = 32'hAA;
    hz_a.wb_rd = 5'd3; hz_a.wb_reg_write = 1'b1; hz_a.wb_data = 32'hBB;
    hz_a.ex_rs1 = 5'd3; hz_a.ex_rs1_data = 32'h11;
    hz_a.ex_rs2 = 5'd9; hz_a.ex_rs2_data = 32'h22;
    #1;
    vecs++; if (hz_a.fwd_a_sel !== 2'd1) begin errs++; $display("FAIL fwd_mem_sel got %0d want 1", hz_a.fwd_a_sel); end
    vecs++; if (hz_a.op_a !== 32'hAA) begin errs++; $display("FAIL fwd_mem_op got %0h want aa", hz_a.op_a); end
    vecs++; if (hz_a.op_b !== 32'h22) begin errs++; $display("FAIL fwd_b_reg got %0h want 22", hz_a.op_b); end
    hz_a.mem_reg_write = 1'b0; hz_a.ex_rs2 = 5'd3;
    #1;
    vecs++; if (hz_a.fwd_a_sel !== 2'd2) begin errs++; $display("FAIL fwd_wb_sel got %0d want 2", hz_a.fwd_a_sel); end
    vecs++; if (hz_a.op_b !== 32'hBB) begin errs++; $display("FAIL fwd_wb_op_b got %0h want bb", hz_a.op_b); end
    hz_a.ex_rs1 = 5'd0; hz_a.mem_rd = 5'd0; hz_a.mem_reg_write = 1'b1;
    hz_a.wb_rd = 5'd0; hz_a.ex_rs1_data = 32'h33;
    #1;
    vecs++; if (hz_a.fwd_a_sel !== 2'd0) begin errs++; $display("FAIL fwd_x0_sel got %0d want 0", hz_a.fwd_a_sel); end
    vecs++; if (hz_a.op_a !== 32'h33) begin errs++; $display("FAIL fwd_x0_op got %0h want 33", hz_a.op_a); end
    clear_all();
  endtask

  task automatic test_mem_wait();
    do_reset();
    hz_a.mem_mem_access = 1'b1; hz_a.ex_branch_taken = 1'b1;
    hz_b.mem_mem_access = 1'b1;
    #1;
    vecs++; if ({hz_b.pc_en, hz_b.mem_wb_flush} !== 2'b10) begin errs++; $display("FAIL nowait_no_freeze got %b want 10", {hz_b.pc_en, hz_b.mem_wb_flush}); end
    for (int i = 0; i < 3; i++) begin
      vecs++; if ({hz_a.pc_en, hz_a.if_id_en, hz_a.id_ex_en, hz_a.ex_mem_en} !== 4'b0000) begin errs++; $display("FAIL frz%0d_enables got %b want 0000", i, {hz_a.pc_en, hz_a.if_id_en, hz_a.id_ex_en, hz_a.ex_mem_en}); end
      vecs++; if ({hz_a.if_id_flush, hz_a.id_ex_flush, hz_a.mem_wb_flush} !== 3'b001) begin errs++; $display("FAIL frz%0d_flushes got %b want 001", i, {hz_a.if_id_flush, hz_a.id_ex_flush, hz_a.mem_wb_flush}); end
      tick();
    end
    hz_a.ex_branch_taken = 1'b0;
    #1;
    vecs++; if ({hz_a.pc_en, hz_a.ex_mem_en, hz_a.mem_wb_flush} !== 3'b110) begin errs++; $display("FAIL done_outputs got %b want 110", {hz_a.pc_en, hz_a.ex_mem_en, hz_a.mem_wb_flush}); end
    vecs++; if (hz_a.stall_cycles !== 32'd3) begin errs++; $display("FAIL frz_stall_cnt got %0d want 3", hz_a.stall_cycles); end
    vecs++; if (hz_a.flush_count !== 32'd0) begin errs++; $display("FAIL frz_branch_ignored got %0d want 0", hz_a.flush_count); end
    hz_a.mem_mem_access = 1'b0;
    tick();
    vecs++; if (hz_a.pc_en !== 1'b1) begin errs++; $display("FAIL post_done_run got %0h want 1", hz_a.pc_en); end
    clear_all();
  endtask

  task automatic test_branch();
    do_reset();
    hz_a.ex_branch_taken = 1'b1;
    hz_a.ex_mem_read = 1'b1; hz_a.ex_reg_write = 1'b1; hz_a.ex_rd = 5'd5;
    hz_a.id_rs1 = 5'd5; hz_a.id_rs1_used = 1'b1;
    #1;
    vecs++; if ({hz_a.if_id_flush, hz_a.id_ex_flush, hz_a.pc_en} !== 3'b111) begin errs++; $display("FAIL br_over_lu got %b want 111", {hz_a.if_id_flush, hz_a.id_ex_flush, hz_a.pc_en}); end
    tick();
    clear_all();
    #1;
    vecs++; if (hz_a.flush_count !== 32'd1) begin errs++; $display("FAIL br_flush_cnt got %0d want 1", hz_a.flush_count); end
    vecs++; if (hz_a.stall_cycles !== 32'd0) begin errs++; $display("FAIL br_stall_cnt got %0d want 0", hz_a.stall_cycles); end
  endtask

  task automatic test_no_fwd();
    do_reset();
    hz_b.id_rs1 = 5'd7; hz_b.id_rs1_used = 1'b1;
    hz_b.mem_rd = 5'd7; hz_b.mem_reg_write = 1'b1; hz_b.mem_data = 32'hAA;
    hz_b.ex_rs1 = 5'd7; hz_b.ex_rs1_data = 32'h1234;
    #1;
    vecs++; if ({hz_b.pc_en, hz_b.if_id_en, hz_b.id_ex_flush} !== 3'b001) begin errs++; $display("FAIL nf_mem_stall got %b want 001", {hz_b.pc_en, hz_b.if_id_en, hz_b.id_ex_flush}); end
    vecs++; if (hz_b.fwd_a_sel !== 2'd0) begin errs++; $display("FAIL nf_sel got %0d want 0", hz_b.fwd_a_sel); end
    vecs++; if (hz_b.op_a !== 32'h1234) begin errs++; $display("FAIL nf_op_a got %0h want 1234", hz_b.op_a); end
    tick();
    vecs++; if (hz_b.stall_cycles !== 32'd1) begin errs++; $display("FAIL nf_stall_cnt got %0d want 1", hz_b.stall_cycles); end
    hz_b.mem_reg_write = 1'b0; hz_b.wb_rd = 5'd7; hz_b.wb_reg_write = 1'b1;
    #1;
    vecs++; if (hz_b.pc_en !== 1'b1) begin errs++; $display("FAIL nf_wb_no_stall got %0h want 1", hz_b.pc_en); end
    hz_b.wb_reg_write = 1'b0; hz_b.ex_rd = 5'd7; hz_b.ex_reg_write = 1'b1;
    #1;
    vecs++; if (hz_b.pc_en !== 1'b0) begin errs++; $display("FAIL nf_ex_stall got %0h want 0", hz_b.pc_en); end
    hz_b.id_rs1 = 5'd0; hz_b.ex_rd = 5'd0; hz_b.mem_rd = 5'd0; hz_b.mem_reg_write = 1'b1;
    #1;
    vecs++; if (hz_b.pc_en !== 1'b1) begin errs++; $display("FAIL nf_x0 got %0h want 1", hz_b.pc_en); end
    clear_all();
  endtask

  task automatic test_reset_abort();
    do_reset();
    hz_c.mem_mem_access = 1'b1;
    #1;
    vecs++; if (hz_c.pc_en !== 1'b0) begin errs++; $display("FAIL ab_first_freeze got %0h want 0", hz_c.pc_en); end
    tick();
    reset_n = 1'b0;
    #1;
    vecs++; if ({hz_c.ex_mem_en, hz_c.if_id_flush, hz_c.mem_wb_flush} !== 3'b111) begin errs++; $display("FAIL ab_rst_outputs got %b want 111", {hz_c.ex_mem_en, hz_c.if_id_flush, hz_c.mem_wb_flush}); end
    tick();
    reset_n = 1'b1;
    #1;
    vecs++; if (hz_c.stall_cycles !== 32'd0) begin errs++; $display("FAIL ab_stall_clr got %0d want 0", hz_c.stall_cycles); end
    for (int i = 0; i < 4; i++) begin
      vecs++; if ({hz_c.pc_en, hz_c.ex_mem_en, hz_c.mem_wb_flush} !== 3'b001) begin errs++; $display("FAIL ab_refrz%0d got %b want 001", i, {hz_c.pc_en, hz_c.ex_mem_en, hz_c.mem_wb_flush}); end
      tick();
    end
    vecs++; if ({hz_c.pc_en, hz_c.ex_mem_en, hz_c.mem_wb_flush} !== 3'b110) begin errs++; $display("FAIL ab_done got %b want 110", {hz_c.pc_en, hz_c.ex_mem_en, hz_c.mem_wb_flush}); end
    vecs++; if (hz_c.stall_cycles !== 32'd4) begin errs++; $display("FAIL ab_stall_cnt got %0d want 4", hz_c.stall_cycles); end
    hz_c.mem_mem_access = 1'b0;
    tick();
    clear_all();
  endtask

  initial begin
    clear_all();
    test_reset();
    test_load_use();
    test_forward();
    test_mem_wait();
    test_branch();
    test_no_fwd();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
